bus_dma: RTL and testbench
==========================

# bus_dma

Single-channel word-copy engine that acts as a second initiator on the SoC data bus. It presents the same address/write-data/write-enable/read-data signal set the CPU uses toward the bus bridge, so it can copy DRAM regions, or push DRAM words into the LED/digtube windows, without CPU load/store loops. A request/grant pair goes to the bus arbiter. It is the initiator-side counterpart of the bus bridge and its peripherals.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, bus word width
- `LEN_W`, 16, transfer length counter width (words)
- `clk`  in  1  system clock (cpuclk output domain)
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  one-cycle launch pulse; sampled only in IDLE
- `src_addr`  in  ADDR_W  source byte address, latched on accepted start
- `dst_addr`  in  ADDR_W  destination byte address, latched on accepted start
- `len_words`  in  LEN_W  number of words, latched on accepted start
- `busy`  out  1  high in REQ/RD/WR
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  misalignment flag; sticky until next accepted start
- `bus_req`  out  1  bus ownership request
- `bus_gnt`  in  1  ownership grant from arbiter
- `dram_addr`  out  ADDR_W  bus address
- `dram_we`  out  1  bus write strobe
- `dram_wdin`  out  DATA_W  bus write data
- `dram_rd`  in  DATA_W  bus read data, combinational (valid same cycle as address)

## Operation
- States: IDLE, REQ, RD, WR, DONE.
- IDLE: `start`=1 latches src/dst/len and clears `err`.
  - len=0 → DONE (no bus activity).
  - src[1:0]≠0 or dst[1:0]≠0 → `err`=1, → DONE.
  - otherwise → REQ.
- REQ: `bus_req`=1. `bus_gnt`=1 → RD, else stay.
- RD: `dram_addr`=src. If `bus_gnt`, capture `dram_rd` into the word buffer and go to WR. If not, stay in RD and capture nothing.
- WR: `dram_addr`=dst, `dram_wdin`=buffer, `dram_we`=`bus_gnt`. If `bus_gnt`:
  - src+=4 and dst+=4, both wrapping mod 2^ADDR_W.
  - remaining−=1.
  - remaining now 0 → DONE, else → RD.
  - If not granted, stay in WR with the buffer held.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- `start` is ignored outside IDLE. It is not queued.
- `bus_req` is high in REQ, RD and WR. `dram_we` is never high outside WR with a grant.
- When not in RD/WR, `dram_addr` and `dram_wdin` drive 0.
- `rst` mid-transfer: the state returns to IDLE next edge and all outputs reset. Words already written stay written. No `done` is issued.

## Timing
- Reset values: all outputs 0. State IDLE; src, dst, remaining and buffer all 0.
- With `bus_gnt` tied high, for start at cycle 0 and len=N:
  - REQ at cycle 1.
  - Word k read at cycle 2+2k and written at cycle 3+2k.
  - `done` at cycle 2N+2. Throughput is 1 word per 2 cycles.
- Each cycle of grant deassertion adds one cycle of latency. No data is lost.
- len=0 or misaligned: `done` at cycle 1, with `busy` low throughout.
- `done` and `start` in the same cycle: `start` is ignored, because the state is DONE, not IDLE.

## Structure
- Shared package `bus_dma_pkg`:
  - state enum (IDLE, REQ, RD, WR, DONE)
  - `WORD_BYTES`=4
  - `ALIGN_MASK`=2'b11
- The address map constants (DRAM/LED/digtube windows) stay in the existing bus package. The DMA is address-agnostic.
- Single module, no sub-module. The counters and buffer are local registers.

## Test plan
- Copy src=0x0000_0100, dst=0x0000_0200, len=4, gnt tied 1. Required response:
  - writes to 0x200/0x204/0x208/0x20C with the data from 0x100–0x10C
  - `done` at cycle 10
  - `busy` high on cycles 1–9
- len=0 → `done` at cycle 1, `dram_we` never high, `err`=0.
- src=0x0000_0102 → `err`=1 and `done` at cycle 1, no bus request. A following aligned start clears `err`.
- Grant drop: gnt low on cycle 1 and on the cycle of the first WR → completion delayed by 2 cycles, memory contents still correct, `dram_we` never high while gnt=0.
- Wrap: src=0xFFFF_FFFC, len=2 → the second read address is 0x0000_0000.
- `rst` asserted on cycle 5 of a len=4 copy → IDLE on the next edge, outputs 0, no `done`. A new start then completes normally.

Source files
------------

// File: rtl/bus_dma_pkg.sv
// rtl/bus_dma_pkg.sv - shared state encoding and constants for the bus DMA engine
package bus_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } dma_state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/bus_dma.sv
// rtl/bus_dma.sv - single-channel word-copy initiator on the SoC data bus
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              dram_we,
    output logic [DATA_W-1:0] dram_wdin,
    input  logic [DATA_W-1:0] dram_rd
);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              err_q, err_d;
    logic              misaligned;

    // Either address not on a word boundary makes the whole transfer invalid.
    assign misaligned = ((src_addr[1:0] & ALIGN_MASK) != 2'b00) ||
                        ((dst_addr[1:0] & ALIGN_MASK) != 2'b00);

    assign err = err_q;

    // State and datapath registers; reset drops everything back to idle without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    // Next-state and bus outputs; every read/write step waits on the grant so no word is lost.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        buf_d     = buf_q;
        err_d     = err_q;
        busy      = 1'b0;
        done      = 1'b0;
        bus_req   = 1'b0;
        dram_addr = '0;
        dram_we   = 1'b0;
        dram_wdin = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    rem_d = len_words;
                    err_d = 1'b0;
                    if (len_words == '0) begin
                        state_d = ST_DONE;
                    end else if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                busy      = 1'b1;
                bus_req   = 1'b1;
                dram_addr = src_q;
                if (bus_gnt) begin
                    buf_d   = dram_rd;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                busy      = 1'b1;
                bus_req   = 1'b1;
                dram_addr = dst_q;
                dram_wdin = buf_q;
                dram_we   = bus_gnt;
                if (bus_gnt) begin
                    src_d = src_q + ADDR_W'(WORD_BYTES);
                    dst_d = dst_q + ADDR_W'(WORD_BYTES);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_dma.sv
// tb/tb_bus_dma.sv - directed self-checking bench for bus_dma
module tb_bus_dma;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic        err;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdin;
    logic [31:0] dram_rd;

    int n_tests;
    int n_fail;
    int viol;

    logic [39:0] busy_v;
    logic [39:0] req_v;
    logic [39:0] done_v;
    logic [39:0] err_v;
    logic [31:0] addr_tr [0:39];

    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];

    bus_dma #(
        .ADDR_W(32),
        .DATA_W(32),
        .LEN_W (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len_words(len_words),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .dram_addr(dram_addr),
        .dram_we  (dram_we),
        .dram_wdin(dram_wdin),
        .dram_rd  (dram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data is a fixed function of the address.
    assign dram_rd = 32'hDA7A_0000 ^ dram_addr;

    // Log every bus write strobe seen at the clock edge.
    always @(posedge clk) begin
        if (dram_we) begin
            wa_q.push_back(dram_addr);
            wd_q.push_back(dram_wdin);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 carries the start pulse; gnt drops on cycles low_a/low_b; rst pulses on rst_at.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input int low_a, input int low_b, input int rst_at, output int done_at);
        done_at = 99;
        busy_v  = '0;
        req_v   = '0;
        done_v  = '0;
        err_v   = '0;
        viol    = 0;
        wa_q.delete();
        wd_q.delete();
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            start     = (k == 0);
            src_addr  = s;
            dst_addr  = d;
            len_words = n;
            bus_gnt   = !(k == low_a || k == low_b);
            rst       = (k == rst_at);
            @(negedge clk);
            busy_v[k]  = busy;
            req_v[k]   = bus_req;
            done_v[k]  = done;
            err_v[k]   = err;
            addr_tr[k] = dram_addr;
            if (dram_we && !bus_gnt) viol++;
            if (done && done_at == 99) done_at = k;
        end
        start   = 1'b0;
        bus_gnt = 1'b1;
        rst     = 1'b0;
    endtask

    initial begin
        int dat;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len_words = '0;
        bus_gnt   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {busy, done, err, bus_req, dram_we}, 64'h0);
        chk("reset_addr", 64'(dram_addr), 64'h0);
        chk("reset_wdin", 64'(dram_wdin), 64'h0);

        // Plain copy, grant tied high.
        run(32'h0000_0100, 32'h0000_0200, 16'd4, -1, -1, -1, dat);
        chk("copy_done_at", 64'(dat), 64'd10);
        chk("copy_done_pulse", 64'(done_v), 64'h400);
        chk("copy_busy", 64'(busy_v), 64'h3FE);
        chk("copy_req", 64'(req_v), 64'h3FE);
        chk("copy_rd_addr0", 64'(addr_tr[2]), 64'h100);
        chk("copy_rd_addr3", 64'(addr_tr[8]), 64'h10C);
        chk("copy_nwrites", 64'(wa_q.size()), 64'd4);
        if (wa_q.size() == 4) begin
            chk("copy_wa0", 64'(wa_q[0]), 64'h200);
            chk("copy_wa3", 64'(wa_q[3]), 64'h20C);
            chk("copy_wd0", 64'(wd_q[0]), 64'hDA7A_0100);
            chk("copy_wd1", 64'(wd_q[1]), 64'hDA7A_0104);
            chk("copy_wd3", 64'(wd_q[3]), 64'hDA7A_010C);
        end

        // Zero-length transfer.
        run(32'h0000_0100, 32'h0000_0200, 16'd0, -1, -1, -1, dat);
        chk("len0_done_at", 64'(dat), 64'd1);
        chk("len0_nwrites", 64'(wa_q.size()), 64'd0);
        chk("len0_busy", 64'(busy_v), 64'h0);
        chk("len0_err", 64'(err_v), 64'h0);

        // Misaligned source, then an aligned start clears the sticky flag.
        run(32'h0000_0102, 32'h0000_0200, 16'd4, -1, -1, -1, dat);
        chk("mis_done_at", 64'(dat), 64'd1);
        chk("mis_err_c1", 64'(err_v[1]), 64'h1);
        chk("mis_err_sticky", 64'(err_v[39]), 64'h1);
        chk("mis_req", 64'(req_v), 64'h0);
        chk("mis_busy", 64'(busy_v), 64'h0);
        run(32'h0000_0100, 32'h0000_0200, 16'd1, -1, -1, -1, dat);
        chk("clr_err_c0", 64'(err_v[0]), 64'h1);
        chk("clr_err_c1", 64'(err_v[1]), 64'h0);
        chk("clr_done_at", 64'(dat), 64'd4);

        // Grant withheld on the REQ cycle and on the first WR cycle.
        run(32'h0000_0100, 32'h0000_0200, 16'd4, 1, 4, -1, dat);
        chk("gnt_done_at", 64'(dat), 64'd12);
        chk("gnt_busy", 64'(busy_v), 64'hFFE);
        chk("gnt_we_viol", 64'(viol), 64'd0);
        chk("gnt_nwrites", 64'(wa_q.size()), 64'd4);
        if (wa_q.size() == 4) begin
            chk("gnt_wd0", 64'(wd_q[0]), 64'hDA7A_0100);
            chk("gnt_wa2", 64'(wa_q[2]), 64'h208);
            chk("gnt_wd2", 64'(wd_q[2]), 64'hDA7A_0108);
        end

        // Source address wraps past the top of the address space.
        run(32'hFFFF_FFFC, 32'h0000_0300, 16'd2, -1, -1, -1, dat);
        chk("wrap_rd_addr0", 64'(addr_tr[2]), 64'hFFFF_FFFC);
        chk("wrap_rd_addr1", 64'(addr_tr[4]), 64'h0);
        chk("wrap_done_at", 64'(dat), 64'd6);
        chk("wrap_nwrites", 64'(wa_q.size()), 64'd2);
        if (wa_q.size() == 2) begin
            chk("wrap_wd0", 64'(wd_q[0]), 64'h2585_FFFC);
            chk("wrap_wd1", 64'(wd_q[1]), 64'hDA7A_0000);
            chk("wrap_wa1", 64'(wa_q[1]), 64'h304);
        end

        // Reset in cycle 5 of a four-word copy, then a fresh copy.
        run(32'h0000_0100, 32'h0000_0200, 16'd4, -1, -1, 5, dat);
        chk("rst_no_done", 64'(done_v), 64'h0);
        chk("rst_busy_after", 64'(busy_v[39:6]), 64'h0);
        chk("rst_req_c6", 64'(req_v[6]), 64'h0);
        chk("rst_addr_c6", 64'(addr_tr[6]), 64'h0);
        chk("rst_nwrites", 64'(wa_q.size()), 64'd2);
        run(32'h0000_0100, 32'h0000_0400, 16'd2, -1, -1, -1, dat);
        chk("post_rst_done_at", 64'(dat), 64'd6);
        chk("post_rst_nwrites", 64'(wa_q.size()), 64'd2);
        if (wa_q.size() == 2) begin
            chk("post_rst_wa1", 64'(wa_q[1]), 64'h404);
            chk("post_rst_wd1", 64'(wd_q[1]), 64'hDA7A_0104);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
